// File: rtl/lfsr_segment_scheduler.sv
// Steps a segment-probability LFSR through one display frame and streams one
// random 7-segment ON-mask per digit. Optional macro: LFSR_LOCKUP_GUARD_EN.
module lfsr_segment_scheduler #(
    parameter int RNDSIZE         = 32,
    parameter int NB_DIGITS       = 10,
    parameter int SEGS_PER_DIGIT  = 7,
    parameter int STEPS_PER_DIGIT = 8
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic                                            start,
    input  logic                                            abort,
    input  logic [RNDSIZE-1:0]                              seed,
    input  logic [2*NB_DIGITS-1:0]                          prob_vec,
    output logic                                            out_valid,
    input  logic                                            out_ready,
    output logic [SEGS_PER_DIGIT-1:0]                       out_mask,
    output logic [((NB_DIGITS > 1) ? $clog2(NB_DIGITS) : 1)-1:0] out_digit,
    output logic                                            busy,
    output logic                                            done
);

    localparam int DW = (NB_DIGITS > 1) ? $clog2(NB_DIGITS) : 1;
    localparam int SW = (STEPS_PER_DIGIT > 1) ? $clog2(STEPS_PER_DIGIT) : 1;
    localparam logic [DW-1:0] LAST_DIGIT = DW'(NB_DIGITS - 1);
    localparam logic [SW-1:0] LAST_STEP  = SW'(STEPS_PER_DIGIT - 1);

`ifdef LFSR_LOCKUP_GUARD_EN
    localparam logic [RNDSIZE-1:0] LFSR_RST = RNDSIZE'(1);
`else
    localparam logic [RNDSIZE-1:0] LFSR_RST = '0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_STEP,
        S_OUT,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [RNDSIZE-1:0]      lfsr_q, lfsr_d;
    logic [DW-1:0]           digit_q, digit_d;
    logic [SW-1:0]           step_q, step_d;
    logic [2*NB_DIGITS-1:0]  prob_q, prob_d;
    logic [3:0]              thr;
    logic [SEGS_PER_DIGIT-1:0] mask_raw;

    function automatic logic [RNDSIZE-1:0] lfsr_shift(input logic [RNDSIZE-1:0] s);
        return {s[RNDSIZE-2:0], s[RNDSIZE-1] ^ s[3] ^ s[2] ^ s[0]};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q  <= LFSR_RST;
            digit_q <= '0;
            step_q  <= '0;
            prob_q  <= '0;
        end else begin
            lfsr_q  <= lfsr_d;
            digit_q <= digit_d;
            step_q  <= step_d;
            prob_q  <= prob_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        digit_d = digit_q;
        step_d  = step_q;
        prob_d  = prob_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
`ifdef LFSR_LOCKUP_GUARD_EN
                    lfsr_d = (seed == '0) ? RNDSIZE'(1) : seed;
`else
                    lfsr_d = seed;
`endif
                    prob_d  = prob_vec;
                    digit_d = '0;
                    step_d  = '0;
                    state_d = S_STEP;
                end
            end
            S_STEP: begin
`ifdef LFSR_LOCKUP_GUARD_EN
                lfsr_d = (lfsr_q == '0) ? RNDSIZE'(1) : lfsr_shift(lfsr_q);
`else
                lfsr_d = lfsr_shift(lfsr_q);
`endif
                if (step_q == LAST_STEP) begin
                    state_d = S_OUT;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            S_OUT: begin
                // LFSR stays frozen here so the beat is stable under backpressure
                if (out_ready) begin
                    if (digit_q == LAST_DIGIT) begin
                        state_d = S_DONE;
                    end else begin
                        digit_d = digit_q + 1'b1;
                        step_d  = '0;
                        state_d = S_STEP;
                    end
                end
            end
            S_DONE: begin
                digit_d = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides everything but leaves the LFSR where it stood
        if (abort) begin
            state_d = S_IDLE;
            lfsr_d  = lfsr_q;
            digit_d = '0;
            step_d  = '0;
            prob_d  = prob_q;
        end
    end

    always_comb begin
        thr = 4'd8;
        case (prob_q[2*int'(digit_q) +: 2])
            2'b00:   thr = 4'd8;
            2'b01:   thr = 4'd6;
            2'b10:   thr = 4'd4;
            default: thr = 4'd1;
        endcase
    end

    always_comb begin
        mask_raw = '0;
        for (int j = 0; j < SEGS_PER_DIGIT; j++) begin
            mask_raw[j] = (lfsr_q[4*j +: 4] >= thr);
        end
    end

    assign out_valid = (state_q == S_OUT);
    assign out_mask  = (state_q == S_OUT) ? mask_raw : '0;
    assign out_digit = digit_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

endmodule
